// File: rtl/uart_console_rx.sv
// uart_console_rx
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO. It captures
// the SoC console TX stream and hands bytes to a valid/ready consumer.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (even, >= 4)
//   FIFO_DEPTH   : FIFO entries (power of 2, >= 2)
// Ports
//   cpu_clk    : clock, rising edge
//   cpu_rst    : synchronous active-high reset
//   uart_sin   : serial input, idle high, asynchronous to cpu_clk
//   rx_data    : FIFO head byte, meaningful while rx_valid
//   rx_valid   : FIFO not empty
//   rx_ready   : consumer accepts head byte when rx_valid && rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, received byte dropped on full FIFO
//   fifo_count : occupied FIFO entries
module uart_console_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    input  logic                          uart_sin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    // Counter is loaded with (period - 1) and the sample is taken on the edge
    // where it reads zero, so a load on edge T fires on edge T + period.
    localparam logic [CW-1:0] H_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] N_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic sync1, s_in;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sync1 <= 1'b1;
            s_in  <= 1'b1;
        end else begin
            sync1 <= uart_sin;
            s_in  <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          push_req;
    logic          ferr_nxt;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        push_req  = 1'b0;
        ferr_nxt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!s_in) begin
                    cnt_nxt   = H_LOAD;
                    state_nxt = S_START;
                end
            end

            S_START: begin
                if (cnt == '0) begin
                    if (s_in) begin
                        // Line recovered before mid start bit: glitch.
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                        cnt_nxt   = N_LOAD;
                        bit_nxt   = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            S_DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {s_in, shift[7:1]};   // LSB first
                    cnt_nxt   = N_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            S_STOP: begin
                if (cnt == '0) begin
                    if (s_in) begin
                        push_req  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end

            S_BREAK: begin
                // Hold here while the line stays low so a break yields a
                // single frame_err rather than a stream of bogus frames.
                if (s_in) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry an extra wrap bit so full and empty
    // are distinguishable and the count is a plain subtraction.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, do_push;

    assign fifo_count = wr_ptr - rd_ptr;
    assign rx_valid   = (wr_ptr != rd_ptr);
    assign full       = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop        = rx_valid && rx_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push    = push_req && (!full || pop);
    assign rx_data    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overrun <= push_req && full && !pop;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + CNTW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNTW'(1);
            end
        end
    end

endmodule
